// File: rtl/g_mix_pipe_if.sv
// g_mix_pipe_if -- operand/result bundle for the g_mix_pipe G-function pipeline.
//
// Signals:
//   Ce_I            global pipeline advance enable
//   Valid_I         qualifies A_I..D_I, X_I, Y_I, Tag_I
//   A_I..D_I        G state words in
//   X_I, Y_I        message words in
//   Tag_I           opaque sideband data travelling with the operation
//   A_O..D_O        mixed state words out
//   Valid_O         qualifies A_O..D_O and Tag_O
//   Tag_O           tag of the operation currently presented
//   Busy_O          some pipeline stage holds a valid operation
//
// Modports: master drives operands (producer side), slave is the pipeline.
interface g_mix_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 8
);
    logic             Ce_I;
    logic             Valid_I;
    logic [WIDTH-1:0] A_I;
    logic [WIDTH-1:0] B_I;
    logic [WIDTH-1:0] C_I;
    logic [WIDTH-1:0] D_I;
    logic [WIDTH-1:0] X_I;
    logic [WIDTH-1:0] Y_I;
    logic [TAGW-1:0]  Tag_I;
    logic [WIDTH-1:0] A_O;
    logic [WIDTH-1:0] B_O;
    logic [WIDTH-1:0] C_O;
    logic [WIDTH-1:0] D_O;
    logic             Valid_O;
    logic [TAGW-1:0]  Tag_O;
    logic             Busy_O;

    modport master (
        output Ce_I, Valid_I, A_I, B_I, C_I, D_I, X_I, Y_I, Tag_I,
        input  A_O, B_O, C_O, D_O, Valid_O, Tag_O, Busy_O
    );

    modport slave (
        input  Ce_I, Valid_I, A_I, B_I, C_I, D_I, X_I, Y_I, Tag_I,
        output A_O, B_O, C_O, D_O, Valid_O, Tag_O, Busy_O
    );
endinterface

// File: rtl/g_mix_pipe.sv
// g_mix_pipe -- four-stage pipelined BLAKE2/BLAKE3 G mixing function.
//
// Each accepted operation computes, mod 2^WIDTH:
//   a=a+b+x; d=rotr(d^a,R1); c=c+d; b=rotr(b^c,R2)
//   a=a+b+y; d=rotr(d^a,R3); c=c+d; b=rotr(b^c,R4)
// one half-step pair per stage, latency 4 enabled edges, throughput 1/cycle.
//
// Ports:
//   Clk     rising-edge clock
//   Rst     asynchronous active-high reset, clears the whole pipeline
//   mix_if  g_mix_pipe_if.slave: Ce_I/Valid_I/operands in, results/Busy_O out
module g_mix_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 8
) (
    input logic          Clk,
    input logic          Rst,
    g_mix_pipe_if.slave  mix_if
);
    localparam int R1 = (WIDTH == 64) ? 32 : 16;
    localparam int R2 = (WIDTH == 64) ? 24 : 12;
    localparam int R3 = (WIDTH == 64) ? 16 : 8;
    localparam int R4 = (WIDTH == 64) ? 63 : 7;

    typedef logic [WIDTH-1:0] word_t;

    function automatic word_t rotr(input word_t v, input int n);
        return (v >> n) | (v << (WIDTH - n));
    endfunction

    // Plain WIDTH-bit sums drop the carry-out, giving the mod 2^WIDTH wrap.
    function automatic word_t add3(input word_t p, input word_t q, input word_t r);
        return p + q + r;
    endfunction

    word_t           a_p1_q, b_p1_q, c_p1_q, d_p1_q, y_p1_q;
    word_t           a_p1_d, b_p1_d, c_p1_d, d_p1_d, y_p1_d;
    logic [TAGW-1:0] tag_p1_q, tag_p1_d;
    logic            vld_p1_q, vld_p1_d;

    word_t           a_p2_q, b_p2_q, c_p2_q, d_p2_q, y_p2_q;
    word_t           a_p2_d, b_p2_d, c_p2_d, d_p2_d, y_p2_d;
    logic [TAGW-1:0] tag_p2_q, tag_p2_d;
    logic            vld_p2_q, vld_p2_d;

    word_t           a_p3_q, b_p3_q, c_p3_q, d_p3_q;
    word_t           a_p3_d, b_p3_d, c_p3_d, d_p3_d;
    logic [TAGW-1:0] tag_p3_q, tag_p3_d;
    logic            vld_p3_q, vld_p3_d;

    word_t           a_p4_q, b_p4_q, c_p4_q, d_p4_q;
    word_t           a_p4_d, b_p4_d, c_p4_d, d_p4_d;
    logic [TAGW-1:0] tag_p4_q, tag_p4_d;
    logic            vld_p4_q, vld_p4_d;

    always_comb begin
        // Stage 1: first-half a,d. Valid_I=0 enters a bubble.
        vld_p1_d = mix_if.Valid_I;
        a_p1_d   = add3(mix_if.A_I, mix_if.B_I, mix_if.X_I);
        d_p1_d   = rotr(mix_if.D_I ^ a_p1_d, R1);
        b_p1_d   = mix_if.B_I;
        c_p1_d   = mix_if.C_I;
        y_p1_d   = mix_if.Y_I;
        tag_p1_d = mix_if.Tag_I;

        // Stage 2: first-half c,b.
        vld_p2_d = vld_p1_q;
        a_p2_d   = a_p1_q;
        d_p2_d   = d_p1_q;
        c_p2_d   = c_p1_q + d_p1_q;
        b_p2_d   = rotr(b_p1_q ^ c_p2_d, R2);
        y_p2_d   = y_p1_q;
        tag_p2_d = tag_p1_q;

        // Stage 3: second-half a,d using the Y captured at acceptance.
        vld_p3_d = vld_p2_q;
        a_p3_d   = add3(a_p2_q, b_p2_q, y_p2_q);
        d_p3_d   = rotr(d_p2_q ^ a_p3_d, R3);
        b_p3_d   = b_p2_q;
        c_p3_d   = c_p2_q;
        tag_p3_d = tag_p2_q;

        // Stage 4: second-half c,b; these registers are the outputs.
        vld_p4_d = vld_p3_q;
        a_p4_d   = a_p3_q;
        d_p4_d   = d_p3_q;
        c_p4_d   = c_p3_q + d_p3_q;
        b_p4_d   = rotr(b_p3_q ^ c_p4_d, R4);
        tag_p4_d = tag_p3_q;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            {vld_p1_q, a_p1_q, b_p1_q, c_p1_q, d_p1_q, y_p1_q, tag_p1_q} <= '0;
            {vld_p2_q, a_p2_q, b_p2_q, c_p2_q, d_p2_q, y_p2_q, tag_p2_q} <= '0;
            {vld_p3_q, a_p3_q, b_p3_q, c_p3_q, d_p3_q, tag_p3_q}         <= '0;
            {vld_p4_q, a_p4_q, b_p4_q, c_p4_q, d_p4_q, tag_p4_q}         <= '0;
        end else if (mix_if.Ce_I) begin
            {vld_p1_q, a_p1_q, b_p1_q, c_p1_q, d_p1_q, y_p1_q, tag_p1_q} <=
                {vld_p1_d, a_p1_d, b_p1_d, c_p1_d, d_p1_d, y_p1_d, tag_p1_d};
            {vld_p2_q, a_p2_q, b_p2_q, c_p2_q, d_p2_q, y_p2_q, tag_p2_q} <=
                {vld_p2_d, a_p2_d, b_p2_d, c_p2_d, d_p2_d, y_p2_d, tag_p2_d};
            {vld_p3_q, a_p3_q, b_p3_q, c_p3_q, d_p3_q, tag_p3_q} <=
                {vld_p3_d, a_p3_d, b_p3_d, c_p3_d, d_p3_d, tag_p3_d};
            {vld_p4_q, a_p4_q, b_p4_q, c_p4_q, d_p4_q, tag_p4_q} <=
                {vld_p4_d, a_p4_d, b_p4_d, c_p4_d, d_p4_d, tag_p4_d};
        end
    end

    assign mix_if.A_O     = a_p4_q;
    assign mix_if.B_O     = b_p4_q;
    assign mix_if.C_O     = c_p4_q;
    assign mix_if.D_O     = d_p4_q;
    assign mix_if.Tag_O   = tag_p4_q;
    assign mix_if.Valid_O = vld_p4_q;
    assign mix_if.Busy_O  = vld_p1_q | vld_p2_q | vld_p3_q | vld_p4_q;
endmodule

// File: tb/tb_g_mix_pipe.sv
// tb_g_mix_pipe -- drives a 32-bit and a 64-bit g_mix_pipe in lockstep and
// scores their outputs against a behavioural G model.
module tb_g_mix_pipe;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    logic        ce, vi;
    logic [63:0] ia, ib, ic, id, ix, iy;
    logic [7:0]  itag;

    g_mix_pipe_if #(.WIDTH(32), .TAGW(8)) b32 ();
    g_mix_pipe_if #(.WIDTH(64), .TAGW(8)) b64 ();

    g_mix_pipe #(.WIDTH(32), .TAGW(8)) u32 (.Clk(Clk), .Rst(Rst), .mix_if(b32.slave));
    g_mix_pipe #(.WIDTH(64), .TAGW(8)) u64 (.Clk(Clk), .Rst(Rst), .mix_if(b64.slave));

    assign b32.Ce_I = ce;       assign b64.Ce_I = ce;
    assign b32.Valid_I = vi;    assign b64.Valid_I = vi;
    assign b32.A_I = ia[31:0];  assign b64.A_I = ia;
    assign b32.B_I = ib[31:0];  assign b64.B_I = ib;
    assign b32.C_I = ic[31:0];  assign b64.C_I = ic;
    assign b32.D_I = id[31:0];  assign b64.D_I = id;
    assign b32.X_I = ix[31:0];  assign b64.X_I = ix;
    assign b32.Y_I = iy[31:0];  assign b64.Y_I = iy;
    assign b32.Tag_I = itag;    assign b64.Tag_I = itag;

    typedef struct packed {
        logic [63:0] a, b, c, d;
        logic [7:0]  tag;
        logic [31:0] due;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cecount = 0;
    bit   use_ovr = 1'b0;
    exp_t ovr;

    function automatic logic [63:0] rr(input logic [63:0] v, input int n, input int w,
                                       input logic [63:0] m);
        return ((v >> n) | (v << (w - n))) & m;
    endfunction

    function automatic exp_t model(input logic [63:0] a0, b0, c0, d0, x0, y0, input int w);
        logic [63:0] m, a, b, c, d, x, y;
        exp_t r;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = a0 & m; b = b0 & m; c = c0 & m; d = d0 & m; x = x0 & m; y = y0 & m;
        a = (a + b + x) & m; d = rr(d ^ a, (w == 64) ? 32 : 16, w, m);
        c = (c + d) & m;     b = rr(b ^ c, (w == 64) ? 24 : 12, w, m);
        a = (a + b + y) & m; d = rr(d ^ a, (w == 64) ? 16 : 8, w, m);
        c = (c + d) & m;     b = rr(b ^ c, (w == 64) ? 63 : 7, w, m);
        r.a = a; r.b = b; r.c = c; r.d = d; r.tag = '0; r.due = '0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [295:0] obs, input logic [295:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [295:0] obs32();
        return {32'b0, b32.A_O, 32'b0, b32.B_O, 32'b0, b32.C_O, 32'b0, b32.D_O,
                b32.Tag_O, 32'(cecount)};
    endfunction

    function automatic logic [295:0] obs64();
        return {b64.A_O, b64.B_O, b64.C_O, b64.D_O, b64.Tag_O, 32'(cecount)};
    endfunction

    function automatic logic [295:0] snap();
        return {b32.Valid_O, b32.Busy_O, b32.Tag_O, b32.A_O, b32.B_O, b32.C_O, b32.D_O,
                b64.Valid_O, b64.Busy_O, b64.Tag_O, b64.A_O, b64.B_O, b64.C_O, b64.D_O};
    endfunction

    task automatic step();
        exp_t e;
        logic ce_edge;
        if (ce && vi && !Rst) begin
            e = model(ia, ib, ic, id, ix, iy, 32);
            e.tag = itag;
            if (use_ovr) e = ovr;
            e.due = 32'(cecount + 4);
            q32.push_back(e);
            e = model(ia, ib, ic, id, ix, iy, 64);
            e.tag = itag;
            e.due = 32'(cecount + 4);
            q64.push_back(e);
        end
        use_ovr = 1'b0;
        ce_edge = ce && !Rst;
        @(posedge Clk);
        if (ce_edge) cecount++;
        #1;
        if (ce_edge && b32.Valid_O) begin
            if (q32.size() == 0) chk("w32_unexpected_valid", 296'(b32.Valid_O), 296'd0);
            else begin e = q32.pop_front(); chk("w32_result", obs32(), e); end
        end
        if (ce_edge && b64.Valid_O) begin
            if (q64.size() == 0) chk("w64_unexpected_valid", 296'(b64.Valid_O), 296'd0);
            else begin e = q64.pop_front(); chk("w64_result", obs64(), e); end
        end
    endtask

    task automatic rnd_inputs();
        ia = {$urandom, $urandom}; ib = {$urandom, $urandom};
        ic = {$urandom, $urandom}; id = {$urandom, $urandom};
        ix = {$urandom, $urandom}; iy = {$urandom, $urandom};
        itag = 8'($urandom);
    endtask

    logic [295:0] frozen;

    initial begin
        // Reset held with active inputs: nothing may be accepted or shown.
        Rst = 1'b1; ce = 1'b1; vi = 1'b1;
        ia = '1; ib = '1; ic = '1; id = '1; ix = '1; iy = '1; itag = 8'hFF;
        step(); step();
        chk("reset_outputs", snap(), 296'd0);

        // All-zero vector accepted on the first edge after release.
        Rst = 1'b0;
        ia = '0; ib = '0; ic = '0; id = '0; ix = '0; iy = '0; itag = 8'h00;
        ovr = '0; use_ovr = 1'b1;
        step();
        vi = 1'b0;
        step(); step(); step();
        chk("zero_vector_drained", 296'(q32.size() + q64.size()), 296'd0);

        // Single-bit vector with known 32-bit answer.
        vi = 1'b1; ia = 64'd1; itag = 8'h5A;
        ovr = '{a: 64'h11, b: 64'h2022_0202, c: 64'h1101_0100, d: 64'h1100_0100,
                tag: 8'h5A, due: 32'd0};
        use_ovr = 1'b1;
        step();
        vi = 1'b0;
        repeat (4) step();
        chk("single_bit_drained", 296'(q32.size() + q64.size()), 296'd0);

        // 16 back-to-back random operations.
        vi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rnd_inputs();
            step();
        end
        vi = 1'b0;
        repeat (4) step();
        chk("stream_drained", 296'(q32.size() + q64.size()), 296'd0);

        // Stall with two operations in flight.
        vi = 1'b1;
        rnd_inputs(); step();
        rnd_inputs(); step();
        vi = 1'b0;
        step(); step();
        frozen = snap();
        ce = 1'b0; vi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_inputs();
            step();
            chk("stall_frozen", snap(), frozen);
        end
        ce = 1'b1; vi = 1'b0;
        repeat (4) step();
        chk("stall_drained", 296'(q32.size() + q64.size()), 296'd0);
        chk("stall_busy_low", 296'({b32.Busy_O, b64.Busy_O}), 296'd0);

        // Asynchronous reset with three operations in flight.
        vi = 1'b1;
        rnd_inputs(); step();
        rnd_inputs(); step();
        rnd_inputs(); step();
        vi = 1'b0;
        step();
        #2 Rst = 1'b1;
        #1 chk("async_reset_clear", snap(), 296'd0);
        q32.delete(); q64.delete();
        step();
        Rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_no_valid", 296'({b32.Valid_O, b32.Busy_O, b64.Valid_O, b64.Busy_O}),
                296'd0);
        end

        // All-ones wrap-around.
        vi = 1'b1;
        ia = '1; ib = '1; ic = '1; id = '1; ix = '1; iy = '1; itag = 8'hC3;
        step();
        vi = 1'b0;
        repeat (4) step();
        chk("wrap_drained", 296'(q32.size() + q64.size()), 296'd0);
        chk("final_busy_low", 296'({b32.Busy_O, b64.Busy_O}), 296'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
